// File: rtl/simple_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package simple_uart_pkg;

  // Register word indices, decoded from addr[9:2] (byte offset = index * 4).
  localparam logic [7:0] TXDATA_IDX = 8'h00;  // 0x0
  localparam logic [7:0] STATUS_IDX = 8'h01;  // 0x4
  localparam logic [7:0] CTRL_IDX   = 8'h02;  // 0x8
  localparam logic [7:0] CLKDIV_IDX = 8'h03;  // 0xC

  // STATUS bit positions; the FIFO level sits in [15:8].
  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EMPTY_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT  = 2;
  localparam int unsigned STATUS_OVF_BIT   = 3;
  localparam int unsigned STATUS_LVL_LSB   = 8;

  // CTRL bit positions.
  localparam int unsigned CTRL_TX_EN_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; Depth must be a power of two.
// Latency: a pushed entry is visible on data_o / empty_o the cycle after the push.
// Backpressure: pushes while full and pops while empty are silently ignored.
module uart_tx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  // Full is judged on the registered level, so a pop in the same cycle cannot make room.
  assign full_o  = (level_q == FullLvl);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/simple_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus CSRs, TX FIFO, baud counter, serializer.
// Latency: bus response 1 cycle after request; first start bit 2 cycles after a TXDATA write to an idle line.
// Backpressure: none on the bus; a TXDATA write to a full FIFO is dropped with err=1 and sticky ovf.
module simple_uart_tx
  import simple_uart_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,  // only 32 is supported
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned FifoDepth    = 8,
  parameter logic [15:0] ClkDivReset  = 16'd867
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    uart_req_i,
  input  logic                    uart_we_i,
  input  logic [3:0]              uart_be_i,
  input  logic [AddressWidth-1:0] uart_addr_i,
  input  logic [DataWidth-1:0]    uart_wdata_i,
  output logic                    uart_rvalid_o,
  output logic [DataWidth-1:0]    uart_rdata_o,
  output logic                    uart_err_o,
  output logic                    tx_o,
  output logic                    irq_o
);

  localparam int unsigned LvlW = $clog2(FifoDepth) + 1;

  logic [7:0]           reg_idx;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]           fifo_rdata;
  logic [LvlW-1:0]      fifo_level;
  logic [DataWidth-1:0] status_word;
  logic                 launch;

  logic                 rvalid_q, rvalid_d, err_q, err_d, ovf_q, ovf_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic [15:0]          clkdiv_q, clkdiv_d;
  uart_tx_state_e       state_q, state_d;
  logic [15:0]          baud_q, baud_d, div_q, div_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic                 tx_q, tx_d, irq_q, irq_d;

  logic unused_bus;
  assign unused_bus = ^{uart_addr_i[AddressWidth-1:10], uart_addr_i[1:0],
                        uart_wdata_i[DataWidth-1:16], uart_be_i[3:2]};

  assign reg_idx = uart_addr_i[9:2];

  uart_tx_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (uart_wdata_i[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // STATUS read view assembled from live FIFO/FSM state.
  always_comb begin
    status_word                                = '0;
    status_word[STATUS_LVL_LSB +: 8]           = 8'(fifo_level);
    status_word[STATUS_FULL_BIT]               = fifo_full;
    status_word[STATUS_EMPTY_BIT]              = fifo_empty;
    status_word[STATUS_BUSY_BIT]               = (state_q != ST_IDLE);
    status_word[STATUS_OVF_BIT]                = ovf_q;
  end

  // Bus decode: response word, CSR writes and FIFO push.
  always_comb begin
    rvalid_d  = uart_req_i;
    rdata_d   = '0;
    err_d     = 1'b0;
    fifo_push = 1'b0;
    ovf_d     = ovf_q;
    ctrl_d    = ctrl_q;
    clkdiv_d  = clkdiv_q;
    if (uart_req_i) begin
      unique case (reg_idx)
        TXDATA_IDX: begin
          if (uart_we_i && uart_be_i[0]) begin
            if (fifo_full) begin
              err_d = 1'b1;
              ovf_d = 1'b1;
            end else begin
              fifo_push = 1'b1;
            end
          end
        end
        STATUS_IDX: begin
          if (uart_we_i) begin
            if (uart_be_i[0] && uart_wdata_i[STATUS_OVF_BIT]) ovf_d = 1'b0;
          end else begin
            rdata_d = status_word;
          end
        end
        CTRL_IDX: begin
          if (uart_we_i) begin
            if (uart_be_i[0]) ctrl_d = uart_wdata_i[1:0];
          end else begin
            rdata_d[1:0] = ctrl_q;
          end
        end
        CLKDIV_IDX: begin
          if (uart_we_i) begin
            if (uart_be_i[0]) clkdiv_d[7:0]  = uart_wdata_i[7:0];
            if (uart_be_i[1]) clkdiv_d[15:8] = uart_wdata_i[15:8];
          end else begin
            rdata_d[15:0] = clkdiv_q;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // Serializer next-state: start bit, 8 data bits LSB first, stop bit, optional back-to-back launch.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    div_d    = div_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    tx_d     = tx_q;
    launch   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        launch = ctrl_q[CTRL_TX_EN_BIT] & ~fifo_empty;
      end
      ST_START: begin
        if (baud_q == 16'd0) begin
          state_d  = ST_DATA;
          baud_d   = div_q;
          bitcnt_d = 3'd0;
          tx_d     = shreg_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d = div_q;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            shreg_d  = {1'b0, shreg_q[7:1]};
            tx_d     = shreg_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_q == 16'd0) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          launch  = ctrl_q[CTRL_TX_EN_BIT] & ~fifo_empty;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A launch samples CLKDIV once, so mid-frame writes only affect the next frame.
    if (launch) begin
      state_d = ST_START;
      div_d   = clkdiv_q;
      baud_d  = clkdiv_q;
      shreg_d = fifo_rdata;
      tx_d    = 1'b0;
    end
    fifo_pop = launch;
    irq_d    = ctrl_q[CTRL_IRQ_EN_BIT] & fifo_empty & (state_q == ST_IDLE);
  end

  // All control/response state; tx resets high so the line is idle during reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ctrl_q   <= 2'b00;
      clkdiv_q <= ClkDivReset;
      state_q  <= ST_IDLE;
      baud_q   <= 16'd0;
      div_q    <= 16'd0;
      shreg_q  <= 8'd0;
      bitcnt_q <= 3'd0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      ctrl_q   <= ctrl_d;
      clkdiv_q <= clkdiv_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      div_q    <= div_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
    end
  end

  assign uart_rvalid_o = rvalid_q;
  assign uart_rdata_o  = rdata_q;
  assign uart_err_o    = err_q;
  assign tx_o          = tx_q;
  assign irq_o         = irq_q;

endmodule
